// File: rtl/seq_mult_param.sv
// seq_mult_param: WIDTH x WIDTH sequential multiplier built from one DIGIT x DIGIT multiplier.
// Latency: NDIG*NDIG CALC cycles + 1 SIGN cycle; done_flag is high the cycle after that.
// No backpressure: a start in any state restarts; a start while busy abandons the old operation.
module seq_mult_param #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 4
) (
   input  logic               clk,
   input  logic               reset_a,
   input  logic               start,
   input  logic               signed_mode,
   input  logic [WIDTH-1:0]   dataa,
   input  logic [WIDTH-1:0]   datab,
   output logic               busy,
   output logic               done_flag,
   output logic               aborted,
   output logic [2:0]         state_out,
   output logic [2*WIDTH-1:0] product8x8_out
);

   // WIDTH must be a whole number of digits.
   localparam int NDIG = WIDTH / DIGIT;
   localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
   localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      SIGN = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t             state;
   state_t             state_nxt;

   // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1), which still fits.
   logic [WIDTH-1:0]   a_reg;
   logic [WIDTH-1:0]   b_reg;
   logic               neg;
   logic [2*WIDTH-1:0] acc;
   logic [IW-1:0]      i;
   logic [IW-1:0]      j;

   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [DIGIT-1:0]   dig_a;
   logic [DIGIT-1:0]   dig_b;
   logic [2*DIGIT-1:0] dig_prod;
   logic [2*WIDTH-1:0] pp_shift;
   logic               last_pair;

   // Magnitude of each operand; in unsigned mode the MSB is an ordinary bit.
   always_comb begin
      mag_a = (signed_mode && dataa[WIDTH-1]) ? -dataa : dataa;
      mag_b = (signed_mode && datab[WIDTH-1]) ? -datab : datab;
   end

   // Current digit pair, its product, and its weight DIGIT*(i+j) inside the accumulator.
   always_comb begin
      dig_a     = DIGIT'(a_reg >> (DIGIT * int'(i)));
      dig_b     = DIGIT'(b_reg >> (DIGIT * int'(j)));
      dig_prod  = {{DIGIT{1'b0}}, dig_a} * {{DIGIT{1'b0}}, dig_b};
      pp_shift  = (2*WIDTH)'(dig_prod) << (DIGIT * (int'(i) + int'(j)));
      last_pair = (i == LAST) && (j == LAST);
   end

   // State register.
   always_ff @(posedge clk or posedge reset_a) begin
      if (reset_a) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state: start wins in every state, otherwise walk CALC -> SIGN -> DONE -> IDLE.
   always_comb begin
      state_nxt = state;
      if (start) begin
         state_nxt = CALC;
      end else begin
         case (state)
            IDLE:    state_nxt = IDLE;
            CALC:    state_nxt = last_pair ? SIGN : CALC;
            SIGN:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Datapath: load on start, accumulate one digit pair per CALC edge, apply sign in SIGN.
   always_ff @(posedge clk or posedge reset_a) begin
      if (reset_a) begin
         a_reg          <= '0;
         b_reg          <= '0;
         neg            <= 1'b0;
         acc            <= '0;
         i              <= '0;
         j              <= '0;
         product8x8_out <= '0;
         done_flag      <= 1'b0;
         aborted        <= 1'b0;
      end else begin
         done_flag <= 1'b0;
         aborted   <= 1'b0;
         if (start) begin
            a_reg   <= mag_a;
            b_reg   <= mag_b;
            neg     <= signed_mode & (dataa[WIDTH-1] ^ datab[WIDTH-1]);
            acc     <= '0;
            i       <= '0;
            j       <= '0;
            // Restarting a running operation drops it silently apart from this pulse.
            aborted <= (state == CALC) || (state == SIGN);
         end else begin
            case (state)
               CALC: begin
                  acc <= acc + pp_shift;
                  if (j == LAST) begin
                     j <= '0;
                     i <= (i == LAST) ? '0 : i + IW'(1);
                  end else begin
                     j <= j + IW'(1);
                  end
               end
               SIGN: begin
                  product8x8_out <= neg ? -acc : acc;
                  done_flag      <= 1'b1;
               end
               default: begin
               end
            endcase
         end
      end
   end

   // Status decoded straight from the state register.
   always_comb begin
      busy      = (state == CALC) || (state == SIGN);
      state_out = {1'b0, state};
   end

endmodule
